// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (p0 = instruction cache, p1 = data cache) arbiter in front of one
// line-oriented memory port. It holds one outstanding transaction at a time.
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_pN_is_input_valid       request valid
//   i_pN_addr                 byte address
//   i_pN_mem_read/_mem_write  request type; exactly one must be set for the request to count
//   i_pN_din                  write line data
//   o_pN_is_ready             request accepted this cycle
//   o_pN_is_output_valid      one-cycle completion pulse (reads and writes)
//   o_pN_dout                 last read line for this port
//   o_mem_*                   downstream request (valid, type, line address, write data)
//   i_mem_is_output_valid     downstream read data valid
//   i_mem_dout                downstream read data
//   i_mem_ready               downstream ready
//
// Configuration
//   ARB_ROUND_ROBIN_EN        when defined, simultaneous requests alternate using last_grant;
//                             otherwise p1 always wins a tie.
module mem_arbiter #(
  parameter int unsigned LINE_SIZE = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_p0_is_input_valid,
  input  logic [31:0]            i_p0_addr,
  input  logic                   i_p0_mem_read,
  input  logic                   i_p0_mem_write,
  input  logic [LINE_SIZE*8-1:0] i_p0_din,
  input  logic                   i_p1_is_input_valid,
  input  logic [31:0]            i_p1_addr,
  input  logic                   i_p1_mem_read,
  input  logic                   i_p1_mem_write,
  input  logic [LINE_SIZE*8-1:0] i_p1_din,
  output logic                   o_p0_is_ready,
  output logic                   o_p1_is_ready,
  output logic                   o_p0_is_output_valid,
  output logic                   o_p1_is_output_valid,
  output logic [LINE_SIZE*8-1:0] o_p0_dout,
  output logic [LINE_SIZE*8-1:0] o_p1_dout,
  output logic                   o_mem_is_input_valid,
  output logic                   o_mem_read,
  output logic                   o_mem_write,
  output logic [31:0]            o_mem_addr,
  output logic [LINE_SIZE*8-1:0] o_mem_din,
  input  logic                   i_mem_is_output_valid,
  input  logic [LINE_SIZE*8-1:0] i_mem_dout,
  input  logic                   i_mem_ready
);

  localparam int unsigned OFF = $clog2(LINE_SIZE);
  localparam int unsigned DW  = LINE_SIZE * 8;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          r_state, w_state_d;
  logic            r_owner;       // 0 = p0, 1 = p1
  logic            r_last_grant;  // same encoding as r_owner
  logic            r_is_write;
  logic [31:0]     r_addr;
  logic [DW-1:0]   r_din;
  logic [DW-1:0]   r_p0_dout;
  logic [DW-1:0]   r_p1_dout;

  logic w_p0_elig, w_p1_elig, w_p0_wins_tie, w_grant0, w_grant1, w_accept, w_capture;

  // Requests with both or neither type bit set are ignored entirely.
  assign w_p0_elig = i_p0_is_input_valid & (i_p0_mem_read ^ i_p0_mem_write);
  assign w_p1_elig = i_p1_is_input_valid & (i_p1_mem_read ^ i_p1_mem_write);

`ifdef ARB_ROUND_ROBIN_EN
  // p0 wins a tie only when p1 was granted last.
  assign w_p0_wins_tie = r_last_grant;
`else
  // last_grant is still tracked, but ties always go to p1.
  assign w_p0_wins_tie = r_last_grant & 1'b0;
`endif

  assign w_grant0 = w_p0_elig & (~w_p1_elig | w_p0_wins_tie);
  assign w_grant1 = w_p1_elig & (~w_p0_elig | ~w_p0_wins_tie);

  assign w_accept  = (r_state == StIdle) & (w_grant0 | w_grant1);
  assign w_capture = (r_state == StWait) & ~r_is_write & i_mem_is_output_valid;

  assign o_p0_dout = r_p0_dout;
  assign o_p1_dout = r_p1_dout;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_is_write   <= 1'b0;
      r_addr       <= '0;
      r_din        <= '0;
      r_p0_dout    <= '0;
      r_p1_dout    <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_owner      <= w_grant1;
        r_last_grant <= w_grant1;
        r_is_write   <= w_grant1 ? i_p1_mem_write : i_p0_mem_write;
        r_addr       <= w_grant1 ? i_p1_addr : i_p0_addr;
        r_din        <= w_grant1 ? i_p1_din : i_p0_din;
      end
      if (w_capture) begin
        if (r_owner) r_p1_dout <= i_mem_dout;
        else         r_p0_dout <= i_mem_dout;
      end
    end
  end

  always_comb begin
    w_state_d            = r_state;
    o_p0_is_ready        = 1'b0;
    o_p1_is_ready        = 1'b0;
    o_p0_is_output_valid = 1'b0;
    o_p1_is_output_valid = 1'b0;
    o_mem_is_input_valid = 1'b0;
    o_mem_read           = 1'b0;
    o_mem_write          = 1'b0;
    o_mem_addr           = '0;
    o_mem_din            = '0;
    unique case (r_state)
      StIdle: begin
        o_p0_is_ready = w_grant0;
        o_p1_is_ready = w_grant1;
        if (w_accept) w_state_d = StIssue;
      end
      StIssue: begin
        o_mem_is_input_valid = 1'b1;
        o_mem_read           = ~r_is_write;
        o_mem_write          = r_is_write;
        // Line address: byte address with the in-line offset shifted out.
        o_mem_addr           = r_addr >> OFF;
        o_mem_din            = r_din;
        if (i_mem_ready) w_state_d = StWait;
      end
      StWait: begin
        if (r_is_write ? i_mem_ready : i_mem_is_output_valid) w_state_d = StResp;
      end
      StResp: begin
        o_p0_is_output_valid = ~r_owner;
        o_p1_is_output_valid = r_owner;
        w_state_d            = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    // Nothing is presented to either side while reset is held.
    if (i_reset) begin
      o_p0_is_ready        = 1'b0;
      o_p1_is_ready        = 1'b0;
      o_p0_is_output_valid = 1'b0;
      o_p1_is_output_valid = 1'b0;
      o_mem_is_input_valid = 1'b0;
      o_mem_read           = 1'b0;
      o_mem_write          = 1'b0;
      o_mem_addr           = '0;
      o_mem_din            = '0;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LINE_SIZE, default 16, line size in bytes; OFF = CLOG2(LINE_SIZE).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 p0_is_input_valid / p1_is_input_valid  input  1 each  request valid; p0 = instruction cache, p1 = data cache.
REQ-005 p0_addr / p1_addr  input  32 each  byte address of the request.
REQ-006 p0_mem_read, p0_mem_write / p1_mem_read, p1_mem_write  input  1 each  request type.
REQ-007 p0_din / p1_din  input  LINE_SIZE*8 each  write line data.
REQ-008 p0_is_ready / p1_is_ready  output  1 each  arbiter accepts this port's request this cycle.
REQ-009 p0_is_output_valid / p1_is_output_valid  output  1 each  one-cycle completion pulse, for reads and writes.
REQ-010 p0_dout / p1_dout  output  LINE_SIZE*8 each  read line data.
REQ-011 mem_is_input_valid, mem_read, mem_write  output  1 each  downstream request.
REQ-012 mem_addr  output  32  downstream line address; mem_din  output  LINE_SIZE*8  downstream write data.
REQ-013 mem_is_output_valid  input  1; mem_dout  input  LINE_SIZE*8; mem_ready  input  1  downstream read-valid, read data, ready.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, RESP, holding one outstanding transaction.
REQ-015 A port is eligible when is_input_valid is high and exactly one of mem_read/mem_write is high; ineligible requests are ignored and get no response.
REQ-016 In IDLE, pN_is_ready SHALL be high iff port N is eligible and wins arbitration, or the other port is ineligible; in all other states both are low.
REQ-017 Handshake: is_input_valid & is_ready at posedge SHALL latch port id, addr, type and din, and move to ISSUE; the losing port holds its request.
REQ-018 ISSUE: mem_is_input_valid SHALL be high with latched type, mem_addr = {OFF zeros, latched_addr[31:OFF]}, mem_din = latched din; move to WAIT only on a cycle where mem_ready is high, otherwise hold.
REQ-019 WAIT: a read completes on mem_is_output_valid, with mem_dout captured into the owner's dout register; a write completes on the first cycle with mem_ready high; completion moves to RESP.
REQ-020 RESP: the owner's is_output_valid SHALL be high for exactly one cycle, then IDLE; minimum accept-to-response latency is 3 cycles plus memory latency.
REQ-021 pN_dout SHALL hold its last read value until that port's next read completes; writes do not change it.
REQ-022 Downstream outputs SHALL be 0 outside ISSUE; mem_is_output_valid outside WAIT is ignored.
REQ-023 The arbiter SHALL record the winning port in last_grant on each accept.

Reset
REQ-024 When reset is high, state SHALL go to IDLE, last_grant to 1, and all outputs, dout registers and latched fields to 0; this includes reset in mid-transaction, which drops the transaction with no response.
REQ-025 The first cycle after reset SHALL accept requests normally.

Configuration
REQ-026 With ARB_ROUND_ROBIN_EN defined, on a simultaneous eligible request the port not equal to last_grant SHALL win.
REQ-027 Without ARB_ROUND_ROBIN_EN, p1 SHALL always win ties; last_grant is still maintained but not used.

Verification
REQ-028 p0 read, addr 0x0000_0140, LINE_SIZE 16 -> mem_addr 0x0000_0014, mem_read 1; memory returns 128'hA5..A5 -> p0_dout = A5..A5 and p0_is_output_valid high for exactly 1 cycle.
REQ-029 Both ports read in the same cycle after reset, round robin enabled -> p0 served first, then p1; repeat -> p0 again. Without the macro -> p1 is served first both times.
REQ-030 p1 write, addr 0x200, din 128'h1234; mem_ready low for 5 cycles during ISSUE -> mem_is_input_valid held 5 cycles; response arrives after mem_ready rises in WAIT; p1_dout unchanged.
REQ-031 Reset asserted in WAIT -> next cycle state IDLE, all outputs 0, no p*_is_output_valid; a later mem_is_output_valid is ignored.
REQ-032 p0 valid with both mem_read=1 and mem_write=1 -> p0_is_ready 0, no downstream request; a p1 read issued in the same cycle is served.
